// File: rtl/apu_fs_pkg.sv
// Shared constants and types for the APU frame sequencer and channel 1 length counter.
// CH1_LEN_EXTRA_CLK_EN (optional) enables the extra length clock on len_en 0->1 writes.
package apu_fs_pkg;

  localparam int STEP_W    = 3;
  localparam int LEN_W     = 6;
  localparam int RESTART_W = 3;

  // Bit n set means executing step n raises that tick.
  localparam logic [7:0] STEP_LEN   = 8'b0101_0101;
  localparam logic [7:0] STEP_SWEEP = 8'b0100_0100;
  localparam logic [7:0] STEP_ENV   = 8'b1000_0000;

  localparam logic [LEN_W-1:0] LEN_MAX = 6'd63;
  localparam int RESTART_CYCLES = 4;

  typedef logic [STEP_W-1:0] step_t;

  typedef struct packed {
    logic len;
    logic sweep;
    logic env;
  } frame_pulse_t;

  typedef struct packed {
    logic [LEN_W-1:0] cnt;
    logic             expired;
  } len_state_t;

  function automatic frame_pulse_t step_pulses(input step_t s);
    frame_pulse_t p;
    p.len   = STEP_LEN[s];
    p.sweep = STEP_SWEEP[s];
    p.env   = STEP_ENV[s];
    return p;
  endfunction

  // One length clock: an expired counter is frozen, otherwise count up and flag on wrap.
  function automatic len_state_t len_clock(input len_state_t s);
    len_state_t n;
    n = s;
    if (!s.expired) begin
      if (s.cnt == LEN_MAX) begin
        n.cnt     = '0;
        n.expired = 1'b1;
      end else begin
        n.cnt = s.cnt + 6'd1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/ch1_len_ctr.sv
// Channel 1 length counter: 6-bit up-counter with load, trigger reload and expiry flag.
// CH1_LEN_EXTRA_CLK_EN adds the extra clock when len_en is enabled on an odd frame step.
module ch1_len_ctr
  import apu_fs_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        apu_en,
  input  logic        len_clk,
  input  logic        load,
  input  logic        wr_ctrl,
  input  logic [7:0]  d,
  input  step_t       step,
  output logic        expired
);

  len_state_t len_q, len_d;
  logic       len_en_q, len_en_d;
  logic       trigger;

`ifndef CH1_LEN_EXTRA_CLK_EN
  logic unused_step;
  assign unused_step = ^step;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    len_d    = len_q;
    len_en_d = len_en_q;
    trigger  = apu_en & wr_ctrl & d[7];

    // A load or trigger in the same cycle suppresses the regular length clock.
    if (apu_en && len_clk && len_en_q && !load && !trigger) begin
      len_d = len_clock(len_q);
    end

    // Length loads are accepted even while the APU is disabled.
    if (load) begin
      len_d.cnt = d[LEN_W-1:0];
    end

    if (apu_en && wr_ctrl) begin
`ifdef CH1_LEN_EXTRA_CLK_EN
      if (d[6] && !len_en_q && step[0]) begin
        len_d = len_clock(len_d);
      end
`endif
      len_en_d = d[6];
      if (trigger) begin
        if (len_d.expired) len_d.cnt = '0;
        len_d.expired = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q    <= '0;
      len_en_q <= 1'b0;
    end else begin
      len_q    <= len_d;
      len_en_q <= len_en_d;
    end
  end

  assign expired = len_q.expired;

endmodule

// File: rtl/apu_frame_seq.sv
// APU frame sequencer: 512 Hz edge detect, 8-step frame counter, tick pulses,
// channel 1 restart timer; wraps ch1_len_ctr (see CH1_LEN_EXTRA_CLK_EN there).
module apu_frame_seq
  import apu_fs_pkg::*;
(
  input  logic        ajer_2mhz,
  input  logic        napu_reset,
  input  logic        apu_en,
  input  logic        horu_512hz,
  input  logic        ff11_wr,
  input  logic        ff14_wr,
  input  logic [7:0]  d,
  output logic        len_clk,
  output logic        sweep_clk,
  output logic        env_clk,
  output logic [2:0]  step,
  output logic        ch1_restart,
  output logic        ch1_len_expired
);

  logic                 horu_q, horu_d;
  step_t                step_q, step_d;
  frame_pulse_t         pulse_q, pulse_d;
  logic                 restart_q, restart_d;
  logic [RESTART_W-1:0] rs_cnt_q, rs_cnt_d;
  logic                 tick;
  logic                 trigger;

  always_comb begin
    horu_d    = horu_512hz;
    tick      = horu_512hz & ~horu_q;
    trigger   = apu_en & ff14_wr & d[7];

    step_d    = step_q;
    pulse_d   = '0;
    if (!apu_en) begin
      step_d = '0;
    end else if (tick) begin
      pulse_d = step_pulses(step_q);
      step_d  = step_q + 3'd1;
    end

    // rs_cnt counts the high cycles still owed after the current one.
    rs_cnt_d  = rs_cnt_q;
    restart_d = 1'b0;
    if (!apu_en) begin
      rs_cnt_d = '0;
    end else if (trigger) begin
      restart_d = 1'b1;
      rs_cnt_d  = RESTART_W'(RESTART_CYCLES - 1);
    end else if (rs_cnt_q != '0) begin
      restart_d = 1'b1;
      rs_cnt_d  = rs_cnt_q - 3'd1;
    end
  end

  always_ff @(posedge ajer_2mhz) begin
    if (!napu_reset) begin
      horu_q    <= 1'b0;
      step_q    <= '0;
      pulse_q   <= '0;
      restart_q <= 1'b0;
      rs_cnt_q  <= '0;
    end else begin
      horu_q    <= horu_d;
      step_q    <= step_d;
      pulse_q   <= pulse_d;
      restart_q <= restart_d;
      rs_cnt_q  <= rs_cnt_d;
    end
  end

  ch1_len_ctr u_ch1_len_ctr (
    .clk     (ajer_2mhz),
    .rst_n   (napu_reset),
    .apu_en  (apu_en),
    .len_clk (pulse_q.len),
    .load    (ff11_wr),
    .wr_ctrl (ff14_wr),
    .d       (d),
    .step    (step_q),
    .expired (ch1_len_expired)
  );

  assign len_clk     = pulse_q.len;
  assign sweep_clk   = pulse_q.sweep;
  assign env_clk     = pulse_q.env;
  assign step        = step_q;
  assign ch1_restart = restart_q;

endmodule
